// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the core request/response channel and the
// memory_v2 access channel of the load/store unit.
//
// Ports grouped here:
//   core request : req_valid, req_ready, req_write, req_funct3, req_addr, req_wdata
//   core response: resp_valid, resp_rdata, resp_err
//   memory_v2    : mem_addr, mem_data_in, mem_data_out, mem_write_enable, mem_read_enable
//
// Handshake: a request transfers on the rising clk edge where
// req_valid && req_ready are both high. req_valid may be held high while
// req_ready is low and it is simply ignored (no queue). resp_valid is a
// one-cycle pulse with no backpressure; resp_err and resp_rdata are only
// meaningful while resp_valid is high.
//
// Modports:
//   slave  : the load/store unit itself
//   master : the environment (core + memory_v2) around the unit
interface load_store_unit_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_funct3;
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   logic                  resp_valid;
   logic [31:0]           resp_rdata;
   logic                  resp_err;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_data_in;
   logic [31:0]           mem_data_out;
   logic                  mem_write_enable;
   logic                  mem_read_enable;

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_data_in, mem_write_enable, mem_read_enable
   );

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_out,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_data_in, mem_write_enable, mem_read_enable
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: converts RISC-V byte-addressed loads/stores
// (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide memory_v2 accesses.
// Sub-word stores are done as read-modify-write because memory_v2 has a
// single 32-bit write enable. Misaligned, out-of-range and illegal-funct3
// requests are answered with resp_err and never touch memory.
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active-low
//   bus       : load_store_unit_if.slave (core request/response + memory_v2)
//   fsm_state : current FSM state, for debug/observation
//
// Latency from the accept edge: error 1, SW 2, load 3, SB/SH 4 cycles.
module load_store_unit #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                clk,
   input  logic                rst,
   load_store_unit_if.slave    bus,
   output logic [2:0]          fsm_state
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD   = 3'd1;
   localparam logic [2:0] RDW  = 3'd2;
   localparam logic [2:0] WR   = 3'd3;
   localparam logic [2:0] RESP = 3'd4;

   logic [2:0]            state;
   logic                  write_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH-1:0] word_addr_q;
   logic [1:0]            byte_sel_q;
   logic [31:0]           wdata_q;
   logic [31:0]           word_q;     // word to be written in WR
   logic [31:0]           rdata_q;    // extended load result (0 for stores/errors)
   logic                  err_q;

   logic                  range_err;
   logic                  align_err;
   logic                  funct3_err;
   logic                  req_err;
   logic                  accept;

   logic [7:0]            sel_byte;
   logic [15:0]           sel_half;
   logic [31:0]           load_value;
   logic [31:0]           merged_word;

   assign accept = (state == IDLE) && bus.req_valid;

   // Error classification is done on the incoming request so the accept
   // edge can already route an error straight to RESP.
   always_comb begin
      range_err  = (bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
      align_err  = 1'b0;
      funct3_err = 1'b0;
      case (bus.req_funct3)
         3'd1, 3'd5: align_err = bus.req_addr[0];
         3'd2:       align_err = bus.req_addr[1:0] != 2'b00;
         default:    align_err = 1'b0;
      endcase
      if (bus.req_write) begin
         funct3_err = bus.req_funct3 > 3'd2;
      end else begin
         funct3_err = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                      (bus.req_funct3 == 3'd7);
      end
      req_err = range_err || align_err || funct3_err;
   end

   // Little-endian lane selection from the word memory_v2 returns in RDW.
   always_comb begin
      sel_byte = bus.mem_data_out[{byte_sel_q, 3'b000} +: 8];
      sel_half = bus.mem_data_out[{byte_sel_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'd0:    load_value = {{24{sel_byte[7]}}, sel_byte};
         3'd1:    load_value = {{16{sel_half[15]}}, sel_half};
         3'd2:    load_value = bus.mem_data_out;
         3'd4:    load_value = {24'd0, sel_byte};
         3'd5:    load_value = {16'd0, sel_half};
         default: load_value = 32'd0;
      endcase
   end

   // Read-modify-write merge for SB/SH (funct3 0 = byte, 1 = halfword).
   always_comb begin
      merged_word = bus.mem_data_out;
      if (funct3_q[1:0] == 2'd0) begin
         merged_word[{byte_sel_q, 3'b000} +: 8] = wdata_q[7:0];
      end else begin
         merged_word[{byte_sel_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         write_q     <= 1'b0;
         funct3_q    <= 3'd0;
         word_addr_q <= '0;
         byte_sel_q  <= 2'd0;
         wdata_q     <= 32'd0;
         word_q      <= 32'd0;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  write_q     <= bus.req_write;
                  funct3_q    <= bus.req_funct3;
                  word_addr_q <= bus.req_addr[ADDR_WIDTH+1:2];
                  byte_sel_q  <= bus.req_addr[1:0];
                  wdata_q     <= bus.req_wdata;
                  word_q      <= bus.req_wdata;  // SW writes wdata unchanged
                  rdata_q     <= 32'd0;
                  err_q       <= req_err;
                  if (req_err) begin
                     state <= RESP;
                  end else if (bus.req_write && (bus.req_funct3 == 3'd2)) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: state <= RDW;
            RDW: begin
               if (write_q) begin
                  word_q <= merged_word;
                  state  <= WR;
               end else begin
                  rdata_q <= load_value;
                  state   <= RESP;
               end
            end
            WR:      state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // All outputs decode from the state register, so an asynchronous reset
   // drops the memory enables and the response immediately.
   assign bus.req_ready        = (state == IDLE);
   assign bus.mem_read_enable  = (state == RD);
   assign bus.mem_write_enable = (state == WR);
   assign bus.mem_data_in      = (state == WR) ? word_q : 32'd0;
   assign bus.mem_addr         = (state != IDLE) ? word_addr_q : '0;
   assign bus.resp_valid       = (state == RESP);
   assign bus.resp_err         = (state == RESP) && err_q;
   assign bus.resp_rdata       = (state == RESP) ? rdata_q : 32'd0;
   assign fsm_state            = state;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with
// a behavioural memory_v2 (1-cycle read latency, single write enable).
module tb_load_store_unit;
   localparam int AW = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] fsm_state;
   int         n_vec = 0;
   int         n_err = 0;

   load_store_unit_if #(.ADDR_WIDTH(AW)) bus ();

   load_store_unit #(.ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memory_v2 model ----------------
   logic [31:0] mem_model [0:(1<<AW)-1];
   int          we_count   = 0;
   int          both_count = 0;

   always @(posedge clk) begin
      if (bus.mem_write_enable) begin
         mem_model[bus.mem_addr] <= bus.mem_data_in;
         we_count <= we_count + 1;
      end
      if (bus.mem_read_enable) bus.mem_data_out <= mem_model[bus.mem_addr];
      if (bus.mem_write_enable && bus.mem_read_enable) both_count <= both_count + 1;
   end

   // ---------------- per-transaction trace (index = cycles after accept) ----------------
   logic          tr_we    [1:12];
   logic          tr_re    [1:12];
   logic          tr_rv    [1:12];
   logic          tr_err   [1:12];
   logic          tr_rdy   [1:12];
   logic [31:0]   tr_rdata [1:12];
   logic [31:0]   tr_din   [1:12];
   logic [AW-1:0] tr_addr  [1:12];
   int            tr_nresp;
   logic          tr_anyen;

   task sample(input int k);
      tr_we[k]    = bus.mem_write_enable;
      tr_re[k]    = bus.mem_read_enable;
      tr_rv[k]    = bus.resp_valid;
      tr_err[k]   = bus.resp_err;
      tr_rdy[k]   = bus.req_ready;
      tr_rdata[k] = bus.resp_rdata;
      tr_din[k]   = bus.mem_data_in;
      tr_addr[k]  = bus.mem_addr;
      if (bus.resp_valid) tr_nresp++;
      if (bus.mem_write_enable || bus.mem_read_enable) tr_anyen = 1'b1;
   endtask

   // Drives one request for a single accept edge and traces 6 cycles after it.
   task run_req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      tr_nresp = 0;
      tr_anyen = 1'b0;
      @(negedge clk);
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      sample(1);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         sample(k);
      end
   endtask

   // ---------------- tests ----------------
   task test_reset;
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h10;
      bus.req_wdata  = 32'h55555555;
      #1;
      n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0h want 1", bus.req_ready); end
      n_vec++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %0h want 0", bus.resp_valid); end
      n_vec++; if (bus.resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err: got %0h want 0", bus.resp_err); end
      n_vec++; if (bus.resp_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %08h want 0", bus.resp_rdata); end
      n_vec++; if (bus.mem_addr !== '0) begin n_err++; $display("FAIL rst_mem_addr: got %0h want 0", bus.mem_addr); end
      n_vec++; if (bus.mem_data_in !== 32'd0) begin n_err++; $display("FAIL rst_mem_din: got %08h want 0", bus.mem_data_in); end
      n_vec++; if ((bus.mem_write_enable | bus.mem_read_enable) !== 1'b0) begin n_err++; $display("FAIL rst_enables: got we=%0h re=%0h want 0", bus.mem_write_enable, bus.mem_read_enable); end
      // requests are ignored while rst is low, even across clock edges
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++; if (fsm_state !== 3'd0) begin n_err++; $display("FAIL rst_ignore_req_state: got %0d want 0", fsm_state); end
      n_vec++; if (bus.mem_write_enable !== 1'b0) begin n_err++; $display("FAIL rst_ignore_req_we: got %0h want 0", bus.mem_write_enable); end
      bus.req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task test_sw_lw;
      run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
      n_vec++; if (tr_we[1] !== 1'b1) begin n_err++; $display("FAIL sw_we_t1: got %0h want 1", tr_we[1]); end
      n_vec++; if (tr_addr[1] !== 10'd4) begin n_err++; $display("FAIL sw_addr_t1: got %0h want 4", tr_addr[1]); end
      n_vec++; if (tr_din[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_din_t1: got %08h want DEADBEEF", tr_din[1]); end
      n_vec++; if (tr_rv[1] !== 1'b0) begin n_err++; $display("FAIL sw_no_resp_t1: got %0h want 0", tr_rv[1]); end
      n_vec++; if ({tr_rv[2], tr_err[2]} !== 2'b10) begin n_err++; $display("FAIL sw_resp_t2: got valid/err=%b want 10", {tr_rv[2], tr_err[2]}); end
      n_vec++; if (tr_rdata[2] !== 32'd0) begin n_err++; $display("FAIL sw_rdata: got %08h want 0", tr_rdata[2]); end
      n_vec++; if (tr_nresp !== 1) begin n_err++; $display("FAIL sw_nresp: got %0d want 1", tr_nresp); end
      n_vec++; if (tr_din[2] !== 32'd0) begin n_err++; $display("FAIL sw_din_after_wr: got %08h want 0", tr_din[2]); end

      run_req(1'b0, 3'd2, 32'h10, 32'h0);
      n_vec++; if ({tr_re[1], tr_we[1]} !== 2'b10) begin n_err++; $display("FAIL lw_re_t1: got re/we=%b want 10", {tr_re[1], tr_we[1]}); end
      n_vec++; if (tr_rv[2] !== 1'b0) begin n_err++; $display("FAIL lw_no_resp_t2: got %0h want 0", tr_rv[2]); end
      n_vec++; if ({tr_rv[3], tr_err[3]} !== 2'b10) begin n_err++; $display("FAIL lw_resp_t3: got valid/err=%b want 10", {tr_rv[3], tr_err[3]}); end
      n_vec++; if (tr_rdata[3] !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rdata: got %08h want DEADBEEF", tr_rdata[3]); end
   endtask

   task test_sub_word_store;
      run_req(1'b1, 3'd0, 32'h11, 32'h000000AA);
      n_vec++; if (tr_re[1] !== 1'b1) begin n_err++; $display("FAIL sb_re_t1: got %0h want 1", tr_re[1]); end
      n_vec++; if (tr_we[2] !== 1'b0) begin n_err++; $display("FAIL sb_no_we_t2: got %0h want 0", tr_we[2]); end
      n_vec++; if (tr_we[3] !== 1'b1) begin n_err++; $display("FAIL sb_we_t3: got %0h want 1", tr_we[3]); end
      n_vec++; if (tr_din[3] !== 32'hDEADAAEF) begin n_err++; $display("FAIL sb_merge: got %08h want DEADAAEF", tr_din[3]); end
      n_vec++; if ({tr_rv[3], tr_rv[4], tr_err[4]} !== 3'b010) begin n_err++; $display("FAIL sb_resp_t4: got %b want 010", {tr_rv[3], tr_rv[4], tr_err[4]}); end
      run_req(1'b0, 3'd2, 32'h10, 32'h0);
      n_vec++; if (tr_rdata[3] !== 32'hDEADAAEF) begin n_err++; $display("FAIL sb_readback: got %08h want DEADAAEF", tr_rdata[3]); end
   endtask

   task test_loads;
      logic [2:0]  f3s  [0:4];
      logic [31:0] adrs [0:4];
      logic [31:0] exps [0:4];
      f3s  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0};
      adrs = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h13};
      exps = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFFFDE};
      for (int i = 0; i < 5; i++) begin
         run_req(1'b0, f3s[i], adrs[i], 32'h0);
         n_vec++; if ({tr_rv[3], tr_err[3]} !== 2'b10) begin n_err++; $display("FAIL load%0d_resp: got valid/err=%b want 10", i, {tr_rv[3], tr_err[3]}); end
         n_vec++; if (tr_rdata[3] !== exps[i]) begin n_err++; $display("FAIL load%0d_rdata: got %08h want %08h", i, tr_rdata[3], exps[i]); end
      end
      run_req(1'b1, 3'd1, 32'h10, 32'h00001234);
      n_vec++; if (tr_din[3] !== 32'hDEAD1234) begin n_err++; $display("FAIL sh_merge: got %08h want DEAD1234", tr_din[3]); end
      n_vec++; if (tr_rv[4] !== 1'b1) begin n_err++; $display("FAIL sh_resp_t4: got %0h want 1", tr_rv[4]); end
      run_req(1'b0, 3'd2, 32'h10, 32'h0);
      n_vec++; if (tr_rdata[3] !== 32'hDEAD1234) begin n_err++; $display("FAIL sh_readback: got %08h want DEAD1234", tr_rdata[3]); end
      run_req(1'b0, 3'd1, 32'h10, 32'h0);
      n_vec++; if (tr_rdata[3] !== 32'h00001234) begin n_err++; $display("FAIL lh_low_positive: got %08h want 00001234", tr_rdata[3]); end
      run_req(1'b0, 3'd0, 32'h10, 32'h0);
      n_vec++; if (tr_rdata[3] !== 32'h00000034) begin n_err++; $display("FAIL lb_byte0: got %08h want 00000034", tr_rdata[3]); end
   endtask

   task test_errors;
      logic        ws   [0:4];
      logic [2:0]  f3s  [0:4];
      logic [31:0] adrs [0:4];
      ws   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      f3s  = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd4};
      adrs = '{32'h12, 32'h13, 32'h1000, 32'h10, 32'h10};
      for (int i = 0; i < 5; i++) begin
         run_req(ws[i], f3s[i], adrs[i], 32'hFFFFFFFF);
         n_vec++; if ({tr_rv[1], tr_err[1]} !== 2'b11) begin n_err++; $display("FAIL err%0d_resp_t1: got valid/err=%b want 11", i, {tr_rv[1], tr_err[1]}); end
         n_vec++; if (tr_rdata[1] !== 32'd0) begin n_err++; $display("FAIL err%0d_rdata: got %08h want 0", i, tr_rdata[1]); end
         n_vec++; if (tr_anyen !== 1'b0) begin n_err++; $display("FAIL err%0d_mem_touched: got %0h want 0", i, tr_anyen); end
         n_vec++; if (tr_nresp !== 1) begin n_err++; $display("FAIL err%0d_nresp: got %0d want 1", i, tr_nresp); end
      end
      run_req(1'b0, 3'd2, 32'h10, 32'h0);
      n_vec++; if (tr_rdata[3] !== 32'hDEAD1234) begin n_err++; $display("FAIL err_mem_intact: got %08h want DEAD1234", tr_rdata[3]); end
   endtask

   task test_back_to_back;
      run_req(1'b1, 3'd2, 32'h14, 32'hCAFEF00D);
      tr_nresp = 0;
      tr_anyen = 1'b0;
      @(negedge clk);
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h10;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_addr = 32'h14;  // second request, valid stays high
      sample(1);
      for (int k = 2; k <= 12; k++) begin
         @(negedge clk);
         sample(k);
         if (k == 5) bus.req_valid = 1'b0;
      end
      for (int k = 1; k <= 3; k++) begin
         n_vec++; if (tr_rdy[k] !== 1'b0) begin n_err++; $display("FAIL b2b_ready_t%0d: got %0h want 0", k, tr_rdy[k]); end
      end
      n_vec++; if (tr_rdy[4] !== 1'b1) begin n_err++; $display("FAIL b2b_ready_t4: got %0h want 1", tr_rdy[4]); end
      n_vec++; if (tr_rdata[3] !== 32'hDEAD1234) begin n_err++; $display("FAIL b2b_first_rdata: got %08h want DEAD1234", tr_rdata[3]); end
      n_vec++; if ({tr_re[4], tr_re[5]} !== 2'b01) begin n_err++; $display("FAIL b2b_second_accept: got re t4/t5=%b want 01", {tr_re[4], tr_re[5]}); end
      n_vec++; if (tr_rv[7] !== 1'b1) begin n_err++; $display("FAIL b2b_second_resp_t7: got %0h want 1", tr_rv[7]); end
      n_vec++; if (tr_rdata[7] !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_second_rdata: got %08h want CAFEF00D", tr_rdata[7]); end
      n_vec++; if (tr_nresp !== 2) begin n_err++; $display("FAIL b2b_nresp: got %0d want 2", tr_nresp); end
   endtask

   task test_reset_abort;
      int base_we;
      int nresp;
      run_req(1'b1, 3'd2, 32'h20, 32'h11111111);
      n_vec++; if (tr_rv[2] !== 1'b1) begin n_err++; $display("FAIL abort_setup_resp: got %0h want 1", tr_rv[2]); end
      base_we = we_count;
      nresp   = 0;
      @(negedge clk);
      bus.req_write  = 1'b1;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'h000000FF;
      bus.req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_vec++; if (bus.mem_read_enable !== 1'b1) begin n_err++; $display("FAIL abort_rd_t1: got %0h want 1", bus.mem_read_enable); end
      @(negedge clk);  // RDW
      rst = 1'b0;
      #1;
      n_vec++; if (fsm_state !== 3'd0) begin n_err++; $display("FAIL abort_state_async: got %0d want 0", fsm_state); end
      n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready_async: got %0h want 1", bus.req_ready); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.resp_valid) nresp++;
      end
      n_vec++; if (nresp !== 0) begin n_err++; $display("FAIL abort_no_resp: got %0d want 0", nresp); end
      n_vec++; if (we_count !== base_we) begin n_err++; $display("FAIL abort_no_write: got %0d writes want %0d", we_count, base_we); end
      n_vec++; if (fsm_state !== 3'd0) begin n_err++; $display("FAIL abort_state_idle: got %0d want 0", fsm_state); end
      run_req(1'b0, 3'd2, 32'h20, 32'h0);
      n_vec++; if (tr_rdata[3] !== 32'h11111111) begin n_err++; $display("FAIL abort_readback: got %08h want 11111111", tr_rdata[3]); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      test_reset();
      test_sw_lw();
      test_sub_word_store();
      test_loads();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      n_vec++; if (both_count !== 0) begin n_err++; $display("FAIL enables_exclusive: got %0d overlaps want 0", both_count); end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
